// File: rtl/transmissor_serial_if.sv
// Parallel-side handshake of the serial transmitter: a word on Din, qualified by
// valid, is taken when the transmitter raises ready.
interface transmissor_serial_if #(
  parameter int NBITS = 4
);
  logic [NBITS-1:0] Din;
  logic             valid;
  logic             ready;

  modport master (output Din, output valid, input  ready);
  modport slave  (input  Din, input  valid, output ready);
endinterface

// File: rtl/transmissor_serial.sv
// Parallel-in, serial-out transmitter: start bit, data MSB first, optional even
// parity, stop bit, each held for BAUD_DIV clock cycles on a registered line.
module transmissor_serial #(
  parameter int NBITS     = 4,
  parameter int BAUD_DIV  = 1,
  parameter int PARITY_EN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  transmissor_serial_if.slave  bus,
  output logic                 Dout_serie,
  output logic                 busy,
  output logic                 done
);

  localparam int BW  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BCW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [BCW-1:0]   bit_q, bit_d;
  logic [NBITS-1:0] shift_q, shift_d, shift_next;
  logic             parity_q, parity_d;
  logic             dout_d, done_d;
  logic             baud_end;

  assign baud_end  = (baud_q == BW'(BAUD_DIV - 1));
  assign bus.ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  // The line and done are computed one cycle ahead so both leave a flop,
  // keeping valid and Din off any combinational path to the outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    dout_d     = Dout_serie;
    done_d     = 1'b0;
    shift_next = shift_q << 1;

    unique case (state_q)
      IDLE: begin
        dout_d = 1'b1;
        if (bus.valid) begin
          state_d  = START;
          shift_d  = bus.Din;
          parity_d = ^bus.Din;
          baud_d   = '0;
          dout_d   = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          dout_d  = shift_q[NBITS-1];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_next;
          bit_d   = bit_q + BCW'(1);
          if (bit_q == BCW'(NBITS - 1)) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              dout_d  = parity_q;
            end else begin
              state_d = STOP;
              dout_d  = 1'b1;
            end
          end else begin
            dout_d = shift_next[NBITS-1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = STOP;
          dout_d  = 1'b1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
          dout_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        dout_d  = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the shift register is cleared on reset as well, so an abandoned
      // frame leaves no stale data behind.
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      Dout_serie <= 1'b1;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      Dout_serie <= dout_d;
      done       <= done_d;
    end
  end

endmodule

// File: tb/tb_transmissor_serial.sv
// Scoreboard bench: two transmitters (4b/div2/parity and 4b/div1/no parity),
// expected frames queued at each handshake and checked cycle by cycle.
module tb_transmissor_serial;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] din_v   [2];
  logic       valid_v [2];
  logic       rdy_s   [2];
  logic       dout_s  [2];
  logic       busy_s  [2];
  logic       done_s  [2];

  logic [3:0] q0[$];
  logic [3:0] q1[$];

  transmissor_serial_if #(.NBITS(4)) bus_a ();
  transmissor_serial_if #(.NBITS(4)) bus_b ();

  assign bus_a.Din   = din_v[0];
  assign bus_a.valid = valid_v[0];
  assign rdy_s[0]    = bus_a.ready;
  assign bus_b.Din   = din_v[1];
  assign bus_b.valid = valid_v[1];
  assign rdy_s[1]    = bus_b.ready;

  transmissor_serial #(.NBITS(4), .BAUD_DIV(2), .PARITY_EN(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave),
    .Dout_serie(dout_s[0]), .busy(busy_s[0]), .done(done_s[0])
  );

  transmissor_serial #(.NBITS(4), .BAUD_DIV(1), .PARITY_EN(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave),
    .Dout_serie(dout_s[1]), .busy(busy_s[1]), .done(done_s[1])
  );

  task automatic check(input string name, input int ch, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d t=%0t: got %b expected %b", name, ch, $time, act, exp);
    end
  endtask

  // Drive one word; the expected frame is queued at the accepting edge.
  task automatic send(input int ch, input logic [3:0] w, input bit keep_valid);
    bit accepted = 0;
    @(negedge clk);
    din_v[ch]   = w;
    valid_v[ch] = 1'b1;
    for (int t = 0; t < 100 && !accepted; t++) begin
      logic r;
      if (t != 0) @(negedge clk);
      r = rdy_s[ch];
      @(posedge clk);
      if (r) begin
        accepted = 1;
        if (ch == 0) q0.push_back(w); else q1.push_back(w);
      end
    end
    if (!accepted) check("send_timeout", ch, 8'd0, 8'd1);
    if (!keep_valid) begin
      @(negedge clk);
      valid_v[ch] = 1'b0;
    end
  endtask

  task automatic monitor(input int ch);
    int bd = (ch == 0) ? 2 : 1;
    bit pe = (ch == 0);
    forever begin
      @(negedge clk);
      if (reset && busy_s[ch]) begin
        logic [3:0] w;
        bit bits[$];
        bit aborted = 0;
        if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
          check("unexpected_frame", ch, 8'd1, 8'd0);
          for (int t = 0; t < 200 && busy_s[ch]; t++) @(negedge clk);
          continue;
        end
        w = (ch == 0) ? q0.pop_front() : q1.pop_front();
        bits.push_back(1'b0);
        for (int i = 3; i >= 0; i--) bits.push_back(w[i]);
        if (pe) bits.push_back(bit'($countones(w) % 2));
        bits.push_back(1'b1);
        for (int idx = 0; idx < bits.size() && !aborted; idx++) begin
          for (int c = 0; c < bd; c++) begin
            if (idx != 0 || c != 0) @(negedge clk);
            if (!reset) begin
              aborted = 1;
              break;
            end
            check("frame_line", ch, {6'd0, dout_s[ch], rdy_s[ch]}, {6'd0, bits[idx], 1'b0});
          end
        end
        if (aborted) continue;
        @(negedge clk);
        if (!reset) continue;
        check("done_cycle", ch, {4'd0, done_s[ch], rdy_s[ch], busy_s[ch], dout_s[ch]},
              8'b0000_1101);
      end else begin
        check("idle", ch, {4'd0, dout_s[ch], rdy_s[ch], busy_s[ch], done_s[ch]},
              8'b0000_1100);
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    valid_v[0] = 1'b1;
    valid_v[1] = 1'b1;
    din_v[0]   = 4'b1010;
    din_v[1]   = 4'b0101;
    fork
      monitor(0);
      monitor(1);
    join_none

    // Reset held with valid high: nothing may start.
    repeat (5) @(negedge clk);
    valid_v[0] = 1'b0;
    valid_v[1] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frames on both configurations.
    fork
      send(0, 4'b1011, 0);
      send(1, 4'b0110, 0);
    join
    repeat (16) @(negedge clk);

    // Busy lockout: a second word offered mid-frame must be ignored.
    send(0, 4'b1001, 0);
    repeat (2) @(negedge clk);
    din_v[0]   = 4'b0111;
    valid_v[0] = 1'b1;
    repeat (6) @(negedge clk);
    valid_v[0] = 1'b0;
    repeat (10) @(negedge clk);

    // Reset during the second data bit acts without a clock edge.
    send(0, 4'b0101, 0);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1 check("rst_async", 0, {4'd0, dout_s[0], rdy_s[0], busy_s[0], done_s[0]}, 8'b0000_1100);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // Back-to-back: valid held, second frame follows after one idle cycle.
    begin
      int done_cyc[$];
      fork
        begin
          send(0, 4'b1111, 1);
          send(0, 4'b0000, 0);
        end
        begin
          for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done_s[0]) done_cyc.push_back(c);
          end
        end
      join
      check("b2b_done_count", 0, 8'(done_cyc.size()), 8'd2);
      if (done_cyc.size() == 2)
        check("b2b_done_gap", 0, 8'(done_cyc[1] - done_cyc[0]), 8'd15);
    end

    // Randomized traffic on both instances with occasional junk while busy.
    fork
      for (int n = 0; n < 30; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(0, 4'($urandom), 0);
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          din_v[0] = 4'($urandom); valid_v[0] = 1'b1;
          @(negedge clk);
          valid_v[0] = 1'b0;
        end
      end
      for (int n = 0; n < 30; n++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(1, 4'($urandom), 0);
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          din_v[1] = 4'($urandom); valid_v[1] = 1'b1;
          @(negedge clk);
          valid_v[1] = 1'b0;
        end
      end
    join

    for (int t = 0; t < 100; t++) begin
      if (q0.size() == 0 && q1.size() == 0 && !busy_s[0] && !busy_s[1]) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("drain_q0", 0, 8'(q0.size()), 8'd0);
    check("drain_q1", 1, 8'(q1.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
